// File: rtl/lcd_pkg.sv
// Shared types, colour constants and helpers for the RGB565 LCD timing generator.
package lcd_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam rgb565_t COL_WHITE   = rgb565_t'(16'hFFFF);
    localparam rgb565_t COL_YELLOW  = rgb565_t'(16'hFFE0);
    localparam rgb565_t COL_CYAN    = rgb565_t'(16'h07FF);
    localparam rgb565_t COL_GREEN   = rgb565_t'(16'h07E0);
    localparam rgb565_t COL_MAGENTA = rgb565_t'(16'hF81F);
    localparam rgb565_t COL_RED     = rgb565_t'(16'hF800);
    localparam rgb565_t COL_BLUE    = rgb565_t'(16'h001F);
    localparam rgb565_t COL_BLACK   = rgb565_t'(16'h0000);

    function automatic int lcd_total(input int active, input int fp, input int sync_w, input int bp);
        return active + fp + sync_w + bp;
    endfunction

    function automatic rgb565_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Combinational test-pattern source: maps pixel (x, y) to an RGB565 colour
// for the latched pattern mode. Registering is done by the timing generator.
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = 480,
    parameter int XW       = 9,
    parameter int YW       = 9
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  pattern_e      mode_q,
    input  rgb565_t       solid_q,
    output rgb565_t       rgb
);

    // Last bar absorbs any remainder when H_ACTIVE is not a multiple of 8.
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE >> 3) : 1;

    logic [XW-1:0] bar_q;
    logic [2:0]    bar;
    logic [7:0]    ramp_x;
    logic          chk;

    always_comb begin
        rgb    = '0;
        bar_q  = x / XW'(BAR_W);
        bar    = (bar_q > XW'(7)) ? 3'd7 : 3'(bar_q);
        ramp_x = 8'(x);
        chk    = (|(x & XW'(16))) ^ (|(y & YW'(16)));
        case (mode_q)
            PAT_SOLID: rgb = solid_q;
            PAT_BARS:  rgb = bar_colour(bar);
            PAT_RAMP:  rgb = '{r: 5'(ramp_x >> 3), g: 6'(ramp_x >> 2), b: 5'(ramp_x >> 3)};
            PAT_CHECK: rgb = chk ? COL_WHITE : COL_BLACK;
            default:   rgb = '0;
        endcase
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised RGB565 parallel-LCD timing generator with selectable test patterns.
// All panel outputs are registered and trail the h/v counters by one pclk.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [15:0]   solid_rgb,
    output logic          LCD_DE,
    output logic          LCD_HSYNC,
    output logic          LCD_VSYNC,
    output logic [4:0]    LCD_R,
    output logic [5:0]    LCD_G,
    output logic [4:0]    LCD_B,
    output logic          frame_start,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y
);

    localparam int H_TOTAL  = lcd_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = lcd_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    if (H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_timing
        $error("lcd_timing_gen: porch and sync widths must be non-zero");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          en_q;
    logic          run;
    logic          en_rise;
    logic          h_last;
    logic          v_last;
    logic          frame_end;
    pattern_e      mode_q;
    rgb565_t       solid_q;
    logic          de_c;
    logic          hs_c;
    logic          vs_c;
    logic          fs_c;
    logic [XW-1:0] x_c;
    logic [YW-1:0] y_c;
    rgb565_t       pat_rgb;

    // The first enabled edge only latches the mode; counting starts on the next one,
    // so pixel (0,0) is always drawn with the freshly latched pattern.
    assign run       = en & en_q;
    assign en_rise   = en & ~en_q;
    assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
    assign frame_end = run & h_last & v_last;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            en_q  <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            en_q <= en;
            if (!run) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            mode_q  <= PAT_SOLID;
            solid_q <= '0;
        end else if (en_rise || frame_end) begin
            mode_q  <= pattern_e'(mode);
            solid_q <= rgb565_t'(solid_rgb);
        end
    end

    always_comb begin
        de_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        hs_c = (h_cnt >= HW'(HS_START)) && (h_cnt <= HW'(HS_END));
        vs_c = (v_cnt >= VW'(VS_START)) && (v_cnt <= VW'(VS_END));
        fs_c = (h_cnt == '0) && (v_cnt == '0);
        x_c  = de_c ? h_cnt[XW-1:0] : '0;
        y_c  = de_c ? v_cnt[YW-1:0] : '0;
    end

    lcd_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_pattern (
        .x       (x_c),
        .y       (y_c),
        .mode_q  (mode_q),
        .solid_q (solid_q),
        .rgb     (pat_rgb)
    );

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            LCD_DE                <= 1'b0;
            LCD_HSYNC             <= ~HS_POL;
            LCD_VSYNC             <= ~VS_POL;
            {LCD_R, LCD_G, LCD_B} <= '0;
            frame_start           <= 1'b0;
            pix_x                 <= '0;
            pix_y                 <= '0;
        end else if (!run) begin
            LCD_DE                <= 1'b0;
            LCD_HSYNC             <= ~HS_POL;
            LCD_VSYNC             <= ~VS_POL;
            {LCD_R, LCD_G, LCD_B} <= '0;
            frame_start           <= 1'b0;
            pix_x                 <= '0;
            pix_y                 <= '0;
        end else begin
            LCD_DE                <= de_c;
            LCD_HSYNC             <= hs_c ? HS_POL : ~HS_POL;
            LCD_VSYNC             <= vs_c ? VS_POL : ~VS_POL;
            {LCD_R, LCD_G, LCD_B} <= de_c ? pat_rgb : '0;
            frame_start           <= fs_c;
            pix_x                 <= x_c;
            pix_y                 <= y_c;
        end
    end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised RGB565 parallel-LCD timing generator and test-pattern source. It generalises the fixed LCDC: all horizontal and vertical timings and sync polarities are parameters, and it adds an enable, four selectable patterns switched glitch-free at frame boundaries, a frame-start strobe, and pixel coordinates for downstream pixel sources. It sits directly behind the board top and drives the panel pins, clocked by the pixel clock.

## Interface
- H_ACTIVE, 480, visible pixels per line
- H_FP, 8, horizontal front porch (pclk cycles)
- H_SYNC, 4, HSYNC width (pclk cycles)
- H_BP, 43, horizontal back porch (pclk cycles)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 8, vertical front porch (lines)
- V_SYNC, 4, VSYNC width (lines)
- V_BP, 12, vertical back porch (lines)
- HS_POL, 0, HSYNC active level
- VS_POL, 0, VSYNC active level
- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  run enable; low holds the generator idle
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 grey ramp, 3 checkerboard
- solid_rgb  in  16  RGB565 colour for mode 0
- LCD_DE  out  1  data enable
- LCD_HSYNC  out  1  horizontal sync
- LCD_VSYNC  out  1  vertical sync
- LCD_R  out  5  red
- LCD_G  out  6  green
- LCD_B  out  5  blue
- frame_start  out  1  one-cycle strobe coincident with pixel (0,0)
- pix_x  out  $clog2(H_ACTIVE)  x of the current output pixel; 0 when DE is low
- pix_y  out  $clog2(V_ACTIVE)  y of the current output pixel; 0 when DE is low

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counter widths are $clog2 of the totals.
- h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1.
- Line order is active, FP, sync, BP. Frame order is the same, counted in whole lines.
- DE = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
- HSYNC is asserted (= HS_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- VSYNC is asserted (= VS_POL) for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It changes only when h_cnt = 0.
- Mode latching:
  - mode_q and solid_q are loaded from mode and solid_rgb when h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, and on en rising.
  - A mode change mid-frame never alters the current frame.
- Patterns (RGB forced to 0 when DE = 0):
  - 0: solid_q.
  - 1: eight bars, bar = min(x / (H_ACTIVE>>3), 7). Colours in order: white, yellow, cyan, green, magenta, red, blue, black.
  - 2: R = x[7:3], G = x[7:2], B = x[7:3]. Grey ramp, repeats every 256 px.
  - 3: white when x[4]^y[4] = 1, else black (16×16 squares).
- en = 0: counters are cleared to 0 synchronously and outputs are held at reset values. After en rises, the frame starts at (0,0).

## Timing
- Reset values: DE 0, HSYNC ~HS_POL, VSYNC ~VS_POL, RGB 0, frame_start 0, pix_x/pix_y 0, counters 0, mode_q 0, solid_q 0.
- All outputs are registered and mutually aligned. They reflect counter state with exactly 1 pclk of latency: the output at edge n+1 reflects the counters at edge n.
- The first active pixel appears 1 cycle after the first enabled edge following reset release or en rising. frame_start pulses on that cycle and on every subsequent (0,0).
- Reset asserted mid-frame forces reset values immediately (asynchronous). Restart from (0,0) is defined as above.
- Parameters with H_ACTIVE not divisible by 8 are legal: the last bar absorbs the remainder. Porch or sync widths of 0 are illegal; this is asserted at elaboration.

## Structure
- Package lcd_pkg contains:
  - pattern enum (PAT_SOLID, PAT_BARS, PAT_RAMP, PAT_CHECK)
  - RGB565 packed struct
  - the eight bar-colour constants
  - a function computing totals
- Sub-module lcd_pattern_gen: combinational pattern function of (x, y, mode_q, solid_q). The output register stage stays in lcd_timing_gen.

## Test plan
Small parameters for all scenarios: H 16/2/3/3 (H_TOTAL 24), V 4/1/2/1 (V_TOTAL 8), frame = 192 cycles.
- Reset then en=1, mode 0, solid_rgb=16'hF800 → DE high 16 of every 24 cycles on lines 0–3; RGB = R 31, G 0, B 0 while DE; frame_start every 192 cycles.
- Sync check → HSYNC low 3 cycles beginning 18 cycles after DE rise; VSYNC low for 48 cycles beginning 120 cycles after frame_start, edges coincident with the line start; inverted when HS_POL=VS_POL=1.
- mode 1 → bars 2 px wide: x=0,1 white (FFFF); x=14,15 black (0000); x=10 red (F800).
- mode 3 with H_ACTIVE 64, V_ACTIVE 32 → pixel (16,0) white, (16,16) black, (0,0) black.
- mode changed 0→2 mid-frame → current frame stays solid; next frame after frame_start shows ramp, with pixel (8,y) = R 1, G 2, B 1.
- en dropped mid-line, and separately rst pulsed mid-frame → outputs go to reset values (DE 0, syncs inactive, RGB 0); on resume, frame_start occurs 1 cycle after the first enabled edge.
